// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and output decode for the multicycle control unit.
package ctrl_pkg;

  localparam int ST_W  = 5;
  localparam int CNT_W = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  typedef enum logic [ST_W-1:0] {
    S_RESET      = 5'd0,  S_FETCH  = 5'd1,  S_FETCH_WAIT = 5'd2,  S_DECODE = 5'd3,
    S_EXEC_R     = 5'd4,  S_WB_R   = 5'd5,  S_EXEC_I     = 5'd6,  S_WB_I   = 5'd7,
    S_ADDR       = 5'd8,  S_MEM_RD = 5'd9,  S_MEM_WAIT   = 5'd10, S_WB_MEM = 5'd11,
    S_MEM_WR     = 5'd12, S_BRANCH = 5'd13, S_JUMP       = 5'd14, S_EXC    = 5'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mdr_load;
    logic       a_load;
    logic       b_load;
    logic       alu_out_load;
    logic       epc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic funct_valid(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
    case (f)
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Moore decode; `last` marks the final cycle of a wait state.
  function automatic ctrl_t ctrl_decode(input state_t st, input logic last, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH, S_FETCH_WAIT: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = (st == S_FETCH_WAIT) && last;
        c.pc_write  = (st == S_FETCH_WAIT) && last;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.a_load       = 1'b1;
        c.b_load       = 1'b1;
        c.alu_src_b    = SRCB_IMM_SH;
        c.alu_op       = ALU_ADD;
        c.alu_out_load = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_B;
        c.alu_op       = alu_for_funct(f);
        c.alu_out_load = 1'b1;
      end
      S_WB_R: begin
        c.reg_dst   = REGDST_RD;
        c.reg_write = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_IMM;
        c.alu_op       = ALU_ADD;
        c.alu_out_load = 1'b1;
      end
      S_WB_I: begin
        c.reg_dst   = REGDST_RT;
        c.reg_write = 1'b1;
      end
      S_MEM_RD, S_MEM_WAIT: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        c.mdr_load = (st == S_MEM_WAIT) && last;
      end
      S_WB_MEM: begin
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
      S_EXC: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_SUB;
        c.epc_write = 1'b1;
        c.pc_source = PCSRC_EXC;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating memory wait counter: clear on wait entry, count while enabled, flag the last cycle.
module mem_wait_counter
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done,
  output logic done_nxt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count value, saturating at the last wait cycle.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (en && (cnt_r != LAST)) begin
      cnt_nxt_s = cnt_r + 3'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign done     = (cnt_r == LAST);
  assign done_nxt = (cnt_nxt_s == LAST);

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control FSM with registered Moore outputs.
// Optional CTRL_OVERFLOW_EXC_EN: arithmetic overflow in EXEC_R(add/sub)/EXEC_I traps to EXC.
module control_unit_mc
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MDRLoad,
  output logic               ALoad,
  output logic               BLoad,
  output logic               ALUOutLoad,
  output logic               EPCWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic [1:0]         RegDst,
  output logic               MemToReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state_r;
  state_t state_nxt_s;
  ctrl_t  ctrl_r;
  logic   wait_clr_s;
  logic   wait_en_s;
  logic   wait_done_s;
  logic   wait_done_nxt_s;
  logic   last_nxt_s;
  logic   ovf_trap_r_s;
  logic   ovf_trap_i_s;

`ifdef CTRL_OVERFLOW_EXC_EN
  assign ovf_trap_r_s = overflow && ((funct == F_ADD) || (funct == F_SUB));
  assign ovf_trap_i_s = overflow;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign ovf_trap_r_s    = 1'b0;
  assign ovf_trap_i_s    = 1'b0;
`endif

  assign wait_clr_s = (state_r == S_FETCH) || (state_r == S_MEM_RD);
  assign wait_en_s  = (state_r == S_FETCH_WAIT) || (state_r == S_MEM_WAIT);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .clr      (wait_clr_s),
    .en       (wait_en_s),
    .done     (wait_done_s),
    .done_nxt (wait_done_nxt_s)
  );

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RESET:      state_nxt_s = S_FETCH;
      S_FETCH:      state_nxt_s = S_FETCH_WAIT;
      S_FETCH_WAIT: state_nxt_s = wait_done_s ? S_DECODE : S_FETCH_WAIT;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt_s = funct_valid(funct) ? S_EXEC_R : S_EXC;
          OP_ADDI:      state_nxt_s = S_EXEC_I;
          OP_LW, OP_SW: state_nxt_s = S_ADDR;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          OP_J:         state_nxt_s = S_JUMP;
          default:      state_nxt_s = S_EXC;
        endcase
      end
      S_EXEC_R:   state_nxt_s = ovf_trap_r_s ? S_EXC : S_WB_R;
      S_EXEC_I:   state_nxt_s = ovf_trap_i_s ? S_EXC : S_WB_I;
      S_ADDR:     state_nxt_s = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt_s = S_MEM_WAIT;
      S_MEM_WAIT: state_nxt_s = wait_done_s ? S_WB_MEM : S_MEM_WAIT;
      default:    state_nxt_s = S_FETCH;
    endcase
  end

  // The output register must know one cycle ahead whether the wait state it enters is the last one.
  assign last_nxt_s = ((state_nxt_s == S_FETCH_WAIT) || (state_nxt_s == S_MEM_WAIT)) && wait_done_nxt_s;

  // State and output registers; reset clears both asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RESET;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      ctrl_r  <= ctrl_decode(state_nxt_s, last_nxt_s, funct);
    end
  end

  assign PCWrite    = ctrl_r.pc_write | ((state_r == S_BRANCH) & zero);
  assign IRWrite    = ctrl_r.ir_write;
  assign MDRLoad    = ctrl_r.mdr_load;
  assign ALoad      = ctrl_r.a_load;
  assign BLoad      = ctrl_r.b_load;
  assign ALUOutLoad = ctrl_r.alu_out_load;
  assign EPCWrite   = ctrl_r.epc_write;
  assign RegWrite   = ctrl_r.reg_write;
  assign MemRead    = ctrl_r.mem_read;
  assign MemWrite   = ctrl_r.mem_write;
  assign IorD       = ctrl_r.iord;
  assign RegDst     = ctrl_r.reg_dst;
  assign MemToReg   = ctrl_r.mem_to_reg;
  assign ALUSrcA    = ctrl_r.alu_src_a;
  assign ALUSrcB    = ctrl_r.alu_src_b;
  assign ALUOp      = ctrl_r.alu_op;
  assign PCSource   = ctrl_r.pc_source;
  assign state_dbg  = STATE_W'(state_r);

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench: per-cycle expected state/outputs queued per instruction, compared at negedge.
module tb_control_unit_mc;
  import ctrl_pkg::state_t;
  import ctrl_pkg::S_RESET;
  import ctrl_pkg::S_FETCH;
  import ctrl_pkg::S_FETCH_WAIT;
  import ctrl_pkg::S_DECODE;
  import ctrl_pkg::S_EXEC_R;
  import ctrl_pkg::S_WB_R;
  import ctrl_pkg::S_EXEC_I;
  import ctrl_pkg::S_WB_I;
  import ctrl_pkg::S_ADDR;
  import ctrl_pkg::S_MEM_RD;
  import ctrl_pkg::S_MEM_WAIT;
  import ctrl_pkg::S_WB_MEM;
  import ctrl_pkg::S_MEM_WR;
  import ctrl_pkg::S_BRANCH;
  import ctrl_pkg::S_JUMP;
  import ctrl_pkg::S_EXC;

`ifdef CTRL_OVERFLOW_EXC_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic pcw, irw, mdr, al, bl, aol, epc, rw, mr, mw, iord;
    logic [1:0] rdst;
    logic m2r, srca;
    logic [1:0] srcb;
    logic [2:0] op;
    logic [1:0] pcs;
  } ov_t;

  typedef struct packed {
    state_t st;
    ov_t    o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, zero, overflow;
  logic [5:0] opcode, funct;
  logic pcw1, irw1, mdr1, al1, bl1, aol1, epc1, rw1, mr1, mw1, iord1, m2r1, srca1;
  logic pcw3, irw3, mdr3, al3, bl3, aol3, epc3, rw3, mr3, mw3, iord3, m2r3, srca3;
  logic [1:0] rdst1, srcb1, pcs1, rdst3, srcb3, pcs3;
  logic [2:0] op1, op3;
  logic [4:0] sd1, sd3;
  ov_t o1, o3;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit sel3 = 1'b0;

  assign o1 = {pcw1, irw1, mdr1, al1, bl1, aol1, epc1, rw1, mr1, mw1, iord1, rdst1, m2r1, srca1, srcb1, op1, pcs1};
  assign o3 = {pcw3, irw3, mdr3, al3, bl3, aol3, epc3, rw3, mr3, mw3, iord3, rdst3, m2r3, srca3, srcb3, op3, pcs3};

  control_unit_mc #(.MEM_WAIT(1), .STATE_W(5)) dut1 (
    .clk(clk), .reset(rst1), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PCWrite(pcw1), .IRWrite(irw1), .MDRLoad(mdr1), .ALoad(al1), .BLoad(bl1), .ALUOutLoad(aol1),
    .EPCWrite(epc1), .RegWrite(rw1), .MemRead(mr1), .MemWrite(mw1), .IorD(iord1), .RegDst(rdst1),
    .MemToReg(m2r1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ALUOp(op1), .PCSource(pcs1), .state_dbg(sd1)
  );

  control_unit_mc #(.MEM_WAIT(3), .STATE_W(5)) dut3 (
    .clk(clk), .reset(rst3), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PCWrite(pcw3), .IRWrite(irw3), .MDRLoad(mdr3), .ALoad(al3), .BLoad(bl3), .ALUOutLoad(aol3),
    .EPCWrite(epc3), .RegWrite(rw3), .MemRead(mr3), .MemWrite(mw3), .IorD(iord3), .RegDst(rdst3),
    .MemToReg(m2r3), .ALUSrcA(srca3), .ALUSrcB(srcb3), .ALUOp(op3), .PCSource(pcs3), .state_dbg(sd3)
  );

  function automatic ov_t exp_out(input state_t s, input bit last, input logic [5:0] fn, input logic z);
    ov_t o;
    o = '0;
    case (s)
      S_FETCH:      begin o.mr = 1'b1; o.srcb = 2'b01; o.op = 3'b001; end
      S_FETCH_WAIT: begin o.mr = 1'b1; o.srcb = 2'b01; o.op = 3'b001; o.irw = last; o.pcw = last; end
      S_DECODE:     begin o.al = 1'b1; o.bl = 1'b1; o.srcb = 2'b11; o.op = 3'b001; o.aol = 1'b1; end
      S_EXEC_R: begin
        o.srca = 1'b1; o.aol = 1'b1;
        case (fn)
          6'h20:   o.op = 3'b001;
          6'h22:   o.op = 3'b010;
          6'h24:   o.op = 3'b011;
          6'h25:   o.op = 3'b100;
          6'h2A:   o.op = 3'b111;
          default: o.op = 3'b000;
        endcase
      end
      S_WB_R:           begin o.rdst = 2'b01; o.rw = 1'b1; end
      S_EXEC_I, S_ADDR: begin o.srca = 1'b1; o.srcb = 2'b10; o.op = 3'b001; o.aol = 1'b1; end
      S_WB_I:           begin o.rw = 1'b1; end
      S_MEM_RD:         begin o.iord = 1'b1; o.mr = 1'b1; end
      S_MEM_WAIT:       begin o.iord = 1'b1; o.mr = 1'b1; o.mdr = last; end
      S_WB_MEM:         begin o.m2r = 1'b1; o.rw = 1'b1; end
      S_MEM_WR:         begin o.iord = 1'b1; o.mw = 1'b1; end
      S_BRANCH:         begin o.srca = 1'b1; o.op = 3'b010; o.pcs = 2'b01; o.pcw = z; end
      S_JUMP:           begin o.pcs = 2'b10; o.pcw = 1'b1; end
      S_EXC:            begin o.srcb = 2'b01; o.op = 3'b010; o.epc = 1'b1; o.pcs = 2'b11; o.pcw = 1'b1; end
      default:          o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input state_t s, input bit last);
    exp_t e;
    e.st = s;
    e.o  = exp_out(s, last, funct, zero);
    q.push_back(e);
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov, input int mw);
    opcode = op; funct = fn; zero = z; overflow = ov;
    push(S_FETCH, 1'b0);
    for (int i = 0; i < mw; i++) push(S_FETCH_WAIT, i == mw - 1);
    push(S_DECODE, 1'b0);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
          push(S_EXEC_R, 1'b0);
          if (OVF_EN && ov && (fn == 6'h20 || fn == 6'h22)) push(S_EXC, 1'b0);
          else push(S_WB_R, 1'b0);
        end else push(S_EXC, 1'b0);
      end
      6'h08: begin
        push(S_EXEC_I, 1'b0);
        if (OVF_EN && ov) push(S_EXC, 1'b0);
        else push(S_WB_I, 1'b0);
      end
      6'h23: begin
        push(S_ADDR, 1'b0); push(S_MEM_RD, 1'b0);
        for (int i = 0; i < mw; i++) push(S_MEM_WAIT, i == mw - 1);
        push(S_WB_MEM, 1'b0);
      end
      6'h2B:   begin push(S_ADDR, 1'b0); push(S_MEM_WR, 1'b0); end
      6'h04:   push(S_BRANCH, 1'b0);
      6'h02:   push(S_JUMP, 1'b0);
      default: push(S_EXC, 1'b0);
    endcase
  endtask

  task automatic drain(input string tag, input int n);
    exp_t e;
    ov_t  oo;
    int   k;
    k = n;
    while (q.size() > 0 && k > 0) begin
      @(negedge clk);
      e  = q.pop_front();
      oo = sel3 ? o3 : o1;
      check({tag, "_state"}, 32'(sel3 ? sd3 : sd1), 32'(e.st));
      check({tag, "_out"}, 32'(oo), 32'(e.o));
      check({tag, "_rw_and_mw"}, 32'(oo.rw & oo.mw), 32'd0);
      k--;
    end
  endtask

  task automatic run1(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    push_instr(op, fn, z, ov, 1);
    drain(tag, q.size());
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(sd1), 32'(S_RESET));
    check("reset_out", 32'(o1), 32'd0);
    rst1 = 1'b0;

    run1("add",      6'h00, 6'h20, 1'b1, 1'b0);
    run1("sub",      6'h00, 6'h22, 1'b0, 1'b0);
    run1("and",      6'h00, 6'h24, 1'b1, 1'b1);
    run1("or",       6'h00, 6'h25, 1'b0, 1'b0);
    run1("slt",      6'h00, 6'h2A, 1'b1, 1'b0);
    run1("addi",     6'h08, 6'h11, 1'b1, 1'b0);
    run1("lw",       6'h23, 6'h00, 1'b1, 1'b1);
    run1("sw",       6'h2B, 6'h00, 1'b1, 1'b0);
    run1("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0);
    run1("beq_not",  6'h04, 6'h00, 1'b0, 1'b0);
    run1("jump",     6'h02, 6'h00, 1'b1, 1'b0);
    run1("bad_op",   6'h3F, 6'h20, 1'b0, 1'b0);
    run1("bad_funct", 6'h00, 6'h00, 1'b0, 1'b0);
    run1("addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1);
    run1("add_ovf",  6'h00, 6'h20, 1'b0, 1'b1);
    run1("add_after", 6'h00, 6'h20, 1'b0, 1'b0);

    // Switch to the three-wait-cycle instance.
    rst1 = 1'b1; sel3 = 1'b1;
    @(negedge clk);
    check("reset3_state", 32'(sd3), 32'(S_RESET));
    check("reset3_out", 32'(o3), 32'd0);
    rst3 = 1'b0;
    push_instr(6'h23, 6'h00, 1'b0, 1'b0, 3);
    drain("lw_w3", q.size());

    // Abort a load in its first memory wait cycle.
    push_instr(6'h23, 6'h00, 1'b0, 1'b0, 3);
    drain("lw_abort", 8);
    q.delete();
    #1 rst3 = 1'b1;
    #1;
    check("abort_state", 32'(sd3), 32'(S_RESET));
    check("abort_out", 32'(o3), 32'd0);
    @(negedge clk);
    check("abort_hold_out", 32'(o3), 32'd0);
    rst3 = 1'b0;
    push_instr(6'h2B, 6'h00, 1'b0, 1'b0, 3);
    drain("sw_restart", q.size());
    push_instr(6'h23, 6'h00, 1'b0, 1'b0, 3);
    drain("lw_restart", q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Multicycle control FSM for the datapath.
- Drives every `Load`/write-enable, mux select and ALU operation code for PC, IR, MDR, A, B, ALUOut, EPC, register bank and memory.
- It is the initiator side of the register-enable interface: datapath registers only capture on the enables this block asserts.
- Decodes opcode/funct from IR. Supports lw, sw, beq, j, addi, R-type (add, sub, and, or, slt), plus an invalid-instruction exception.

Parameters:
- MEM_WAIT, 1, memory read wait cycles after the address cycle (legal 1..4).
- STATE_W, 5, width of state register and `state_dbg`.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU overflow flag.
- PCWrite  out  1  PC load.
- IRWrite  out  1  IR load.
- MDRLoad  out  1  MDR load.
- ALoad  out  1  A load.
- BLoad  out  1  B load.
- ALUOutLoad  out  1  ALUOut load.
- EPCWrite  out  1  EPC load.
- RegWrite  out  1  register-bank write.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write.
- IorD  out  1  address mux: 0 = PC, 1 = ALUOut.
- RegDst  out  2  destination select: 00 = rt, 01 = rd.
- MemToReg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- ALUOp  out  3  ALU code.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- state_dbg  out  STATE_W  current state code.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `reset` is asynchronous, active-high: while high, state = RESET and all outputs = 0.
- Output timing:
  - Outputs are Moore (decoded from state only).
  - Sole exception: in BRANCH, `PCWrite = zero`.
- Wait counter:
  - Clears on entering any `*_WAIT` state.
  - Increments each wait cycle.
  - Exit occurs when `cnt == MEM_WAIT-1`.
  - `MemRead`/`IorD` are held stable through all wait cycles.
- States and actions; unlisted outputs = 0:
  - RESET: all outputs 0; next FETCH.
  - FETCH: `MemRead`, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD; next FETCH_WAIT.
  - FETCH_WAIT: holds FETCH outputs. On the last wait cycle also `IRWrite=1`, `PCWrite=1`, PCSource=00 (PC <= PC+4); next DECODE.
  - DECODE: `ALoad`, `BLoad`, ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, `ALUOutLoad` (branch target). Next state by opcode:
    - 0x00 → EXEC_R, but a funct outside {0x20, 0x22, 0x24, 0x25, 0x2A} → EXC.
    - 0x08 → EXEC_I.
    - 0x23 / 0x2B → ADDR.
    - 0x04 → BRANCH.
    - 0x02 → JUMP.
    - any other opcode → EXC.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp from funct (add→ADD, sub→SUB, and→AND, or→OR, slt→SLT), `ALUOutLoad`; next WB_R.
  - WB_R: RegDst=01, MemToReg=0, `RegWrite`; next FETCH.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, `ALUOutLoad`; next WB_I.
  - WB_I: RegDst=00, MemToReg=0, `RegWrite`; next FETCH.
  - ADDR: same outputs as EXEC_I. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: IorD=1, `MemRead`; next MEM_WAIT.
  - MEM_WAIT: holds MEM_RD outputs; `MDRLoad` on the last wait cycle; next WB_MEM.
  - WB_MEM: RegDst=00, MemToReg=1, `RegWrite`; next FETCH.
  - MEM_WR: IorD=1, `MemWrite` for exactly 1 cycle; next FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, `PCWrite = zero`; next FETCH.
  - JUMP: PCSource=10, `PCWrite`; next FETCH.
  - EXC: ALUSrcA=0, ALUSrcB=01, ALUOp=SUB, `EPCWrite` (EPC <= PC-4), PCSource=11, `PCWrite`; next FETCH.
- Cycle counts with MEM_WAIT=1:

  | Instruction | Cycles |
  |---|---|
  | R-type / addi | 5 |
  | lw | 7 |
  | sw | 5 |
  | beq / j | 4 |
  | invalid | 4 |

  Each read wait beyond 1 adds one cycle per memory read.
- Boundary conditions:
  - `RegWrite` and `MemWrite` are never asserted in the same cycle.
  - `reset` mid-instruction aborts immediately to RESET; no partial writes complete after `reset` rises.
  - `zero`/`overflow` are don't-care outside the states that sample them.

Optional Feature:
- Macro: `CTRL_OVERFLOW_EXC_EN`.
- Defined:
  - In EXEC_R with funct add/sub, or in EXEC_I: if `overflow` = 1 at the clock edge, next state is EXC instead of WB.
  - No `RegWrite` occurs for that instruction.
- Undefined: `overflow` is ignored and the port remains present but unused.

Decomposition:
- Shared package `ctrl_pkg` holds:
  - opcode and funct constants;
  - ALU codes: ADD=3'b001, SUB=3'b010, AND=3'b011, OR=3'b100, SLT=3'b111;
  - state encodings, sized STATE_W;
  - mux-select constants for PCSource, ALUSrcB and RegDst.
- One natural sub-module: `mem_wait_counter`, the saturating wait counter with clear/enable/done.

Test Plan:
- Reset → state_dbg=RESET, all outputs 0. First clock after release → FETCH with MemRead=1, ALUSrcB=01.
- opcode=0x00, funct=0x20, MEM_WAIT=1 → FETCH, FETCH_WAIT, DECODE, EXEC_R, WB_R. RegWrite=1 with RegDst=01 only in cycle 5.
- opcode=0x23, MEM_WAIT=3 → MDRLoad pulses once on the 3rd MEM_WAIT cycle; RegWrite with MemToReg=1 follows; 11 cycles total.
- opcode=0x04 with zero=1, then zero=0 → PCWrite=1 with PCSource=01 in BRANCH the first time; PCWrite=0 the second time.
- opcode=0x3F → EXC: EPCWrite=1, PCWrite=1, PCSource=11, then FETCH. With CTRL_OVERFLOW_EXC_EN, addi with overflow=1 → EXC and no RegWrite.
- `reset` asserted during MEM_WAIT → outputs 0 asynchronously, before the next edge; restart at FETCH after release.
